// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// controller state codes and a small decode helper.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // MULT and DIV are the signed forms; the unsigned forms have bit 0 set.
  function automatic logic isSignedOp(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Bit 1 of the op code selects divide over multiply.
  function automatic logic isDivOp(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_step_core.sv
// One iteration of the multiply/divide datapath. Purely combinational; the
// controller feeds the registered state back in once per clock.
module mdu_step_core #(
  parameter int WIDTH = 32
) (
  input  logic             i_isDiv,
  input  logic [WIDTH-1:0] i_accRem,
  input  logic [WIDTH-1:0] i_mq,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_accRem,
  output logic [WIDTH-1:0] o_mq
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  // Multiply adds the multiplicand when the low multiplier bit is set and then
  // shifts {acc, mplier} right; divide shifts {rem, quot} left and keeps the
  // trial subtraction only when the divisor fits into the shifted remainder.
  always_comb begin
    w_sum     = {1'b0, i_accRem} + (i_mq[0] ? {1'b0, i_operand} : '0);
    w_shifted = {i_accRem, i_mq[WIDTH-1]};
    w_fits    = (w_shifted >= {1'b0, i_operand});
    w_diff    = w_shifted[WIDTH-1:0] - i_operand;
    if (i_isDiv) begin
      o_accRem = w_fits ? w_diff : w_shifted[WIDTH-1:0];
      o_mq     = {i_mq[WIDTH-2:0], w_fits};
    end else begin
      o_accRem = w_sum[WIDTH:1];
      o_mq     = {w_sum[0], i_mq[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/pipe_mdu_ctrl.sv
// Sequencing controller for the iterative multiply/divide unit beside the
// EXE-stage ALU. Owns HI/LO and stalls the pipeline only for instructions
// that depend on the unit while it is busy.
module pipe_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             estart,
  input  logic [1:0]       eop,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  input  logic             emfhilo,
  input  logic             ecancel,
  output logic             mdu_stall,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  logic [0:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mq;
  logic [WIDTH-1:0]   r_operand;
  logic [WIDTH-1:0]   r_rawA;
  logic               r_isDiv;
  logic               r_negResult;
  logic               r_negRem;
  logic               r_divZero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_signed;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_nextAcc;
  logic [WIDTH-1:0]   w_nextMq;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_finalHi;
  logic [WIDTH-1:0]   w_finalLo;

  // Operand magnitudes are taken only for the signed forms; the unsigned forms
  // pass through untouched.
  always_comb begin
    w_signed = isSignedOp(eop);
    w_absA   = (w_signed && ea[WIDTH-1]) ? -ea : ea;
    w_absB   = (w_signed && eb[WIDTH-1]) ? -eb : eb;
  end

  // A dependent instruction in EXE is frozen while the unit is busy; an
  // independent ALU instruction never sees a stall.
  always_comb begin
    mdu_busy  = (r_state == ST_RUN);
    mdu_stall = mdu_busy & (estart | emfhilo);
    w_accept  = (r_state == ST_IDLE) & estart & ~ecancel & ~mdu_stall;
    w_last    = (r_state == ST_RUN) && (r_count == CW'(WIDTH - 1));
    mdu_done  = r_done;
    hi        = r_hi;
    lo        = r_lo;
  end

  mdu_step_core #(
    .WIDTH(WIDTH)
  ) u_stepCore (
    .i_isDiv  (r_isDiv),
    .i_accRem (r_acc),
    .i_mq     (r_mq),
    .i_operand(r_operand),
    .o_accRem (w_nextAcc),
    .o_mq     (w_nextMq)
  );

  // The last iteration's output is corrected for sign here so HI/LO can be
  // written on the same edge that finishes the final step. A zero divisor
  // bypasses the datapath result entirely.
  always_comb begin
    w_product = {w_nextAcc, w_nextMq};
    if (r_negResult) begin
      w_product = -w_product;
    end
    w_finalHi = w_product[2*WIDTH-1:WIDTH];
    w_finalLo = w_product[WIDTH-1:0];
    if (r_isDiv) begin
      if (r_divZero) begin
        w_finalHi = r_rawA;
        w_finalLo = DIV0_LO;
      end else begin
        w_finalLo = r_negResult ? -w_nextMq  : w_nextMq;
        w_finalHi = r_negRem    ? -w_nextAcc : w_nextAcc;
      end
    end
  end

  // IDLE latches the operands on an accepted start; RUN steps the datapath
  // once per cycle and retires the result into HI/LO on the last count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_acc       <= '0;
      r_mq        <= '0;
      r_operand   <= '0;
      r_rawA      <= '0;
      r_isDiv     <= 1'b0;
      r_negResult <= 1'b0;
      r_negRem    <= 1'b0;
      r_divZero   <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_RUN;
            r_count     <= '0;
            r_acc       <= '0;
            r_mq        <= isDivOp(eop) ? w_absA : w_absB;
            r_operand   <= isDivOp(eop) ? w_absB : w_absA;
            r_rawA      <= ea;
            r_isDiv     <= isDivOp(eop);
            r_negResult <= w_signed & (ea[WIDTH-1] ^ eb[WIDTH-1]);
            r_negRem    <= w_signed & ea[WIDTH-1];
            r_divZero   <= (eb == '0);
          end
        end
        default: begin
          r_acc   <= w_nextAcc;
          r_mq    <= w_nextMq;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            r_state <= ST_IDLE;
            r_hi    <= w_finalHi;
            r_lo    <= w_finalLo;
            r_done  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// Self-checking bench for pipe_mdu_ctrl: directed scenarios with literal
// expectations plus a randomized phase compared every cycle against a
// behavioural model built on plain 64-bit arithmetic.
module tb_pipe_mdu_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        estart;
  logic [1:0]  eop;
  logic [31:0] ea;
  logic [31:0] eb;
  logic        emfhilo;
  logic        ecancel;
  logic        mdu_stall;
  logic        mdu_busy;
  logic        mdu_done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  logic cmpEn = 1'b0;

  int          mBusyLeft;
  logic [63:0] mPending;
  logic [31:0] mHi;
  logic [31:0] mLo;
  logic        mDone;

  pipe_mdu_ctrl #(
    .WIDTH  (32),
    .DIV0_LO(32'hFFFF_FFFF)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .estart   (estart),
    .eop      (eop),
    .ea       (ea),
    .eb       (eb),
    .emfhilo  (emfhilo),
    .ecancel  (ecancel),
    .mdu_stall(mdu_stall),
    .mdu_busy (mdu_busy),
    .mdu_done (mdu_done),
    .hi       (hi),
    .lo       (lo)
  );

  // Free-running pipeline clock, 10 time units per period.
  always #5 clock = ~clock;

  // Reference result as {hi, lo} from ordinary arithmetic on the operands.
  function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] q;
    logic signed [63:0] r;
    logic [63:0]        p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      2'b00: p = sa * sb;
      2'b01: p = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) begin
          p = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Behavioural model: an accepted op occupies the unit for 32 cycles, then
  // its result lands in HI/LO together with a one-cycle done flag.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mBusyLeft <= 0;
      mPending  <= '0;
      mHi       <= '0;
      mLo       <= '0;
      mDone     <= 1'b0;
    end else begin
      mDone <= 1'b0;
      if (mBusyLeft > 0) begin
        if (mBusyLeft == 1) begin
          mHi   <= mPending[63:32];
          mLo   <= mPending[31:0];
          mDone <= 1'b1;
        end
        mBusyLeft <= mBusyLeft - 1;
      end else if (estart && !ecancel) begin
        mPending  <= refResult(eop, ea, eb);
        mBusyLeft <= 32;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle outside reset the DUT outputs must match the model.
  always @(negedge clock) begin
    if (cmpEn && !reset) begin
      checkOutput("cmpBusy",  {63'd0, mdu_busy},  {63'd0, (mBusyLeft > 0)});
      checkOutput("cmpStall", {63'd0, mdu_stall}, {63'd0, (mBusyLeft > 0) && (estart || emfhilo)});
      checkOutput("cmpDone",  {63'd0, mdu_done},  {63'd0, mDone});
      checkOutput("cmpHi",    {32'd0, hi},        {32'd0, mHi});
      checkOutput("cmpLo",    {32'd0, lo},        {32'd0, mLo});
    end
  end

  task automatic applyStimulus(input logic s, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic mf, input logic c);
    @(posedge clock);
    #1;
    estart  = s;
    eop     = op;
    ea      = a;
    eb      = b;
    emfhilo = mf;
    ecancel = c;
  endtask

  task automatic waitDone(output int busyCnt, output int stallCnt);
    logic seen;
    seen     = 1'b0;
    busyCnt  = 0;
    stallCnt = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clock);
      if (mdu_busy)  busyCnt++;
      if (mdu_stall) stallCnt++;
      if (mdu_done)  seen = 1'b1;
    end
    if (!seen) checkOutput("doneTimeout", 64'd0, 64'd1);
  endtask

  task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
    int busyCnt;
    int stallCnt;
    applyStimulus(1'b1, op, a, b, 1'b0, 1'b0);
    applyStimulus(1'b0, op, a, b, 1'b0, 1'b0);
    waitDone(busyCnt, stallCnt);
    checkOutput({name, "_busyCycles"}, 64'(busyCnt), 64'd32);
    checkOutput({name, "_hi"}, {32'd0, hi}, {32'd0, expHi});
    checkOutput({name, "_lo"}, {32'd0, lo}, {32'd0, expLo});
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int busyCnt;
    int stallCnt;
    reset   = 1'b1;
    estart  = 1'b0;
    eop     = 2'b00;
    ea      = '0;
    eb      = '0;
    emfhilo = 1'b0;
    ecancel = 1'b0;
    #12;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("resetHi",   {32'd0, hi}, 64'd0);
    checkOutput("resetLo",   {32'd0, lo}, 64'd0);
    checkOutput("resetBusy", {63'd0, mdu_busy}, 64'd0);
    checkOutput("resetDone", {63'd0, mdu_done}, 64'd0);
    cmpEn = 1'b1;

    // Pin the reference model to hand-computed results.
    checkOutput("modelMultu", refResult(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    checkOutput("modelMult",  refResult(2'b00, 32'hFFFF_FFFD, 32'd5),         64'hFFFF_FFFF_FFFF_FFF1);
    checkOutput("modelDiv",   refResult(2'b10, 32'hFFFF_FFF9, 32'd2),         64'hFFFF_FFFF_FFFF_FFFD);
    checkOutput("modelDiv0",  refResult(2'b11, 32'd7, 32'd0),                 64'h0000_0007_FFFF_FFFF);
    checkOutput("modelOvf",   refResult(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

    $display("[TB] directed operations");
    runOp("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("multu_donePulse", {63'd0, mdu_done}, 64'd0);
    runOp("mult",  2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
    runOp("div",   2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("divu0", 2'b11, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF);
    runOp("ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    $display("[TB] independent add then mfhi");
    applyStimulus(1'b1, 2'b00, 32'hFFFF_FFFE, 32'h4000_0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("add_noStall", {63'd0, mdu_stall}, 64'd0);
    checkOutput("add_busy",    {63'd0, mdu_busy},  64'd1);
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
    waitDone(busyCnt, stallCnt);
    checkOutput("mfhi_stallCycles", 64'(stallCnt), 64'd31);
    checkOutput("mfhi_releasedAtDone", {63'd0, mdu_stall}, 64'd0);
    checkOutput("mfhi_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    checkOutput("mfhi_lo", {32'd0, lo}, 64'h8000_0000);
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);

    $display("[TB] back-to-back mult then div");
    applyStimulus(1'b1, 2'b00, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 32'd100, 32'hFFFF_FFF9, 1'b0, 1'b0);
    waitDone(busyCnt, stallCnt);
    checkOutput("b2b_divStalled", 64'(stallCnt), 64'd32);
    checkOutput("b2b_mulHi", {32'd0, hi}, 64'h1);
    checkOutput("b2b_mulLo", {32'd0, lo}, 64'h0);
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    waitDone(busyCnt, stallCnt);
    checkOutput("b2b_divBusy", 64'(busyCnt), 64'd32);
    checkOutput("b2b_divHi", {32'd0, hi}, 64'h2);
    checkOutput("b2b_divLo", {32'd0, lo}, 64'hFFFF_FFF2);

    $display("[TB] cancelled start");
    applyStimulus(1'b1, 2'b11, 32'd5, 32'd1, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("cancel_idle", {63'd0, mdu_busy}, 64'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 20, 2'($urandom_range(0, 3)), pickOperand(), pickOperand(),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 36; i++) applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);

    $display("[TB] asynchronous reset mid-operation");
    checkOutput("preReset_idle", {63'd0, mdu_busy}, 64'd0);
    applyStimulus(1'b1, 2'b01, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midReset_busy",  {63'd0, mdu_busy},  64'd0);
    checkOutput("midReset_stall", {63'd0, mdu_stall}, 64'd0);
    checkOutput("midReset_hi",    {32'd0, hi}, 64'd0);
    checkOutput("midReset_lo",    {32'd0, lo}, 64'd0);
    @(negedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("postReset_hi", {32'd0, hi}, 64'd0);
    checkOutput("postReset_done", {63'd0, mdu_done}, 64'd0);

    cmpEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_mdu_ctrl.md
Name: pipe_mdu_ctrl

Overview:
- Sequencing controller for an iterative multiply/divide unit alongside the EXE-stage ALU of the 5-stage pipeline.
- Accepts MULT/MULTU/DIV/DIVU from EXE and runs a 32-step shift-add multiply or restoring divide.
- Owns the HI/LO registers.
- Generates a pipeline stall only when a dependent instruction (mfhi/mflo or a new mul/div) reaches EXE while the unit is busy; independent ALU instructions keep flowing.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.
- DIV0_LO, 32'hFFFF_FFFF, LO value written on divide-by-zero.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- estart  in  1  EXE holds a valid mul/div instruction.
- eop  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- ea  in  WIDTH  rs operand (dividend / multiplicand).
- eb  in  WIDTH  rt operand (divisor / multiplier).
- emfhilo  in  1  EXE holds mfhi/mflo (reads HI/LO).
- ecancel  in  1  EXE instruction squashed this cycle (flush).
- mdu_stall  out  1  freeze PC/IF/ID/EXE this cycle.
- mdu_busy  out  1  operation in progress.
- mdu_done  out  1  one-cycle pulse after HI/LO update.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, active-high): state IDLE, count 0, hi=0, lo=0, mdu_done=0, mdu_busy=0, internal shift regs 0. Reset mid-operation aborts the operation; HI/LO are not updated.
- States: IDLE, RUN.
  - IDLE->RUN on estart & ~ecancel & ~mdu_stall. Latch |ea|, |eb| (abs only for signed ops), sign flags, op, count=0.
  - RUN: one iteration per cycle; count increments to WIDTH-1.
  - RUN->IDLE on the edge where count==WIDTH-1. At that same edge, HI/LO are written with sign-corrected results and mdu_done is set for exactly one cycle.
- Latency: start sampled at edge E0; HI/LO are visible after edge E32, so 32 busy cycles.
- mdu_busy = (state==RUN).
- mdu_stall = mdu_busy & (estart | emfhilo), combinational. An mfhi issued immediately after a start stalls 32 cycles, then reads the new HI/LO in the cycle mdu_done=1.
- Multiply: 64-bit product; hi = upper 32 bits, lo = lower 32 bits. Signed results use two's-complement negation when sign(a)^sign(b).
- Divide: restoring algorithm on magnitudes; lo = quotient, hi = remainder.
  - Signed: quotient negated if sign(a)^sign(b); remainder takes sign of dividend (truncation toward zero).
- Divide-by-zero (eb==0): runs full 32 cycles, then hi = ea as latched (raw), lo = DIV0_LO. No exception.
- Signed overflow DIV 0x80000000 / -1: lo = 0x80000000, hi = 0.
- ecancel with estart in IDLE: not accepted, state unchanged. ecancel while RUN: ignored, since the issued op already committed.
- estart while RUN: stalled, not accepted until the cycle after RUN->IDLE, when state is IDLE and the stall is released.
- HI/LO hold value except at the completion edge. There are no mthi/mtlo writes in this block.

Decomposition:
- Shared package mdu_pkg: op encodings MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11; state encodings ST_IDLE, ST_RUN.
- One sub-module, mdu_step_core: combinational single-iteration datapath.
  - Multiply: conditional add, then shift of {acc, mplier}.
  - Divide: trial subtract, then shift of {rem, quot}.
- The controller holds the FSM, counter, operand/sign latches, the final sign fix and HI/LO.

Test Plan:
- MULTU ea=0xFFFFFFFF eb=0xFFFFFFFF -> mdu_busy high 32 cycles; after completion hi=0xFFFFFFFE, lo=0x00000001; mdu_done pulses once.
- MULT ea=-3 eb=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV ea=-7 eb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU ea=7 eb=0 -> hi=0x00000007, lo=0xFFFFFFFF after 32 cycles. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT, then an independent add, then mfhi -> add proceeds with no stall; mfhi sees mdu_stall=1 until completion, then reads the new hi in the mdu_done cycle.
- Back-to-back MULT then DIV -> DIV stalled 32 cycles, accepted the cycle after completion; both results correct in sequence.
- Reset asserted asynchronously at RUN count=10 -> immediately busy=0, stall=0, hi=lo=0. estart with ecancel=1 in IDLE -> stays IDLE.
